uart_reg_bridge: RTL and testbench

Host-side command engine attached to the FIFO side of the `uart` block. It pops command frames from the UART RX queue, performs single register reads and writes on an internal req/ack register bus, and pushes response bytes into the UART TX queue. It is the other end of the UART's queue interface: it consumes what the receiver enqueues and produces what the transmitter dequeues.

---
 rtl/uart_reg_bridge_if.sv | 29 ++
 rtl/uart_reg_bridge.sv | 148 ++++++++++++++
 tb/tb_uart_reg_bridge.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_bridge_if.sv
// Bundle between the bridge and its surroundings: UART RX/TX queue ports and the
// req/ack register bus. master is the bridge side, slave the queue/bus side.
interface uart_reg_bridge_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int REG_W      = 32
);
   logic                  deq_rxq;
   logic [7:0]            rxq_data;
   logic                  rxq_empty;
   logic                  enq_txq;
   logic [7:0]            txq_data;
   logic                  txq_full;
   logic                  reg_req;
   logic                  reg_we;
   logic [ADDR_WIDTH-1:0] reg_addr;
   logic [REG_W-1:0]      reg_wdata;
   logic [REG_W-1:0]      reg_rdata;
   logic                  reg_ack;

   modport master (
      output deq_rxq, enq_txq, txq_data, reg_req, reg_we, reg_addr, reg_wdata,
      input  rxq_data, rxq_empty, txq_full, reg_rdata, reg_ack
   );

   modport slave (
      input  deq_rxq, enq_txq, txq_data, reg_req, reg_we, reg_addr, reg_wdata,
      output rxq_data, rxq_empty, txq_full, reg_rdata, reg_ack
   );
endinterface

// File: rtl/uart_reg_bridge.sv
// Command engine between the UART queues and the register bus: pops 'W'/'R'
// frames, runs one bus access, pushes 'K', read data or 'E' back to TX.
//
// state    | meaning
// IDLE     | waiting for an opcode byte (never times out)
// GET_ADDR | waiting for the address byte
// GET_DATA | collecting write data bytes, MSB first
// BUS      | request held until ack or timeout
// SEND     | shifting response bytes into the TX queue
module uart_reg_bridge #(
   parameter int ADDR_WIDTH     = 8,
   parameter int REG_BYTES      = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic               i_clk,
   input  logic               i_rst,
   uart_reg_bridge_if.master  bus,
   output logic               o_busy,
   output logic               o_err
);
   localparam int REG_W = 8 * REG_BYTES;
   localparam int CW    = $clog2(REG_BYTES + 1);
   localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [7:0]       OP_W      = 8'h57;
   localparam logic [7:0]       OP_R      = 8'h52;
   localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]    CNT_ALL   = CW'(REG_BYTES);
   localparam logic [CW-1:0]    LAST_BYTE = CW'(REG_BYTES - 1);
   localparam logic [TW-1:0]    TMO_LOAD  = TW'(TIMEOUT_CYCLES);
   localparam logic [REG_W-1:0] K_WORD    = REG_W'(8'h4B) << (REG_W - 8);
   localparam logic [REG_W-1:0] E_WORD    = REG_W'(8'h45) << (REG_W - 8);

   typedef enum logic [2:0] {
      S_IDLE, S_GET_ADDR, S_GET_DATA, S_BUS, S_SEND
   } state_t;

   state_t                state, state_nxt;
   logic                  is_wr, is_err;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [REG_W-1:0]      wdata_q, shift_q;
   logic [CW-1:0]         byte_cnt, send_cnt;
   logic [TW-1:0]         tmo_cnt;

   logic intake, pop, tmo_zero, rx_abort, push, known_op;

   assign intake   = (state == S_IDLE) || (state == S_GET_ADDR) || (state == S_GET_DATA);
   assign pop      = intake && !bus.rxq_empty;
   assign tmo_zero = (tmo_cnt == '0);
   assign rx_abort = ((state == S_GET_ADDR) || (state == S_GET_DATA)) && !pop && tmo_zero;
   assign push     = (state == S_SEND) && !bus.txq_full;
   assign known_op = (bus.rxq_data == OP_W) || (bus.rxq_data == OP_R);

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (pop) state_nxt = known_op ? S_GET_ADDR : S_SEND;
         S_GET_ADDR: if (pop)                             state_nxt = is_wr ? S_GET_DATA : S_BUS;
                     else if (rx_abort)                   state_nxt = S_IDLE;
         S_GET_DATA: if (pop && byte_cnt == LAST_BYTE)    state_nxt = S_BUS;
                     else if (rx_abort)                   state_nxt = S_IDLE;
         S_BUS:      if (bus.reg_ack || tmo_zero)         state_nxt = S_SEND;
         S_SEND:     if (push && send_cnt == CNT_ONE)     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Every entry into BUS happens on a pop, so the pop reload also arms the bus timeout.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         is_wr    <= 1'b0;
         is_err   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         shift_q  <= '0;
         byte_cnt <= '0;
         send_cnt <= '0;
         tmo_cnt  <= '0;
      end else begin
         if (pop)
            tmo_cnt <= TMO_LOAD;
         else if (!intake && state == S_BUS && !tmo_zero)
            tmo_cnt <= tmo_cnt - TW'(1);
         else if ((state == S_GET_ADDR || state == S_GET_DATA) && !tmo_zero)
            tmo_cnt <= tmo_cnt - TW'(1);

         case (state)
            S_IDLE: if (pop) begin
               is_wr    <= (bus.rxq_data == OP_W);
               is_err   <= !known_op;
               byte_cnt <= '0;
               shift_q  <= E_WORD;
               send_cnt <= CNT_ONE;
            end
            S_GET_ADDR: if (pop) addr_q <= bus.rxq_data;
            S_GET_DATA: if (pop) begin
               wdata_q  <= (wdata_q << 8) | REG_W'(bus.rxq_data);
               byte_cnt <= byte_cnt + CNT_ONE;
            end
            S_BUS: if (bus.reg_ack) begin
               is_err   <= 1'b0;
               shift_q  <= is_wr ? K_WORD : bus.reg_rdata;
               send_cnt <= is_wr ? CNT_ONE : CNT_ALL;
            end else if (tmo_zero) begin
               is_err   <= 1'b1;
               shift_q  <= E_WORD;
               send_cnt <= CNT_ONE;
            end
            S_SEND: if (push) begin
               shift_q  <= shift_q << 8;
               send_cnt <= send_cnt - CNT_ONE;
            end
            default: ;
         endcase
      end
   end

   // Outputs are forced low while reset is asserted so nothing is popped or pushed mid-reset.
   always_comb begin
      bus.deq_rxq   = 1'b0;
      bus.enq_txq   = 1'b0;
      bus.txq_data  = '0;
      bus.reg_req   = 1'b0;
      bus.reg_we    = 1'b0;
      bus.reg_addr  = '0;
      bus.reg_wdata = '0;
      o_busy        = 1'b0;
      o_err         = 1'b0;
      if (!i_rst) begin
         bus.deq_rxq = pop;
         bus.enq_txq = push;
         o_busy      = (state != S_IDLE);
         o_err       = rx_abort || (push && is_err);
         if (state == S_SEND) bus.txq_data = shift_q[REG_W-1 -: 8];
         if (state == S_BUS) begin
            bus.reg_req  = 1'b1;
            bus.reg_we   = is_wr;
            bus.reg_addr = addr_q;
            if (is_wr) bus.reg_wdata = wdata_q;
         end
      end
   end
endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge: RX queue model, bus responder and TX
// scoreboard, with frame, timeout, backpressure and reset scenarios.
module tb_uart_reg_bridge;
   localparam int T = 100;

   typedef struct packed {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
   } bus_txn_t;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   logic o_busy, o_err;

   uart_reg_bridge_if #(.ADDR_WIDTH(8), .REG_W(32)) bif ();

   uart_reg_bridge #(.ADDR_WIDTH(8), .REG_BYTES(4), .TIMEOUT_CYCLES(T)) dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .bus    (bif),
      .o_busy (o_busy),
      .o_err  (o_err)
   );

   logic [7:0] rx_q[$];
   logic [7:0] tx_exp[$];
   bus_txn_t   bus_exp[$];

   int checks = 0, failures = 0, cyc = 0;
   int tx_cnt = 0, err_cnt = 0, req_cnt = 0;
   int last_deq_cyc = 0, first_enq_cyc = -1, last_enq_cyc = 0, err_cyc = 0;
   int req_start_cyc = 0, ack_cyc = 0, last_req_len = 0;
   int ack_delay = 0;
   logic [31:0] resp_data = '0;
   bit bp_en = 1'b0;

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [53:0] out_vec();
      return {bif.deq_rxq, bif.enq_txq, bif.txq_data, bif.reg_req, bif.reg_we,
              bif.reg_addr, bif.reg_wdata, o_busy, o_err};
   endfunction

   // RX queue, first-word fall-through; pops commit at the edge that ends a deq cycle
   initial begin
      bit d;
      bif.rxq_empty = 1'b1;
      bif.rxq_data  = 8'h00;
      forever begin
         @(negedge i_clk);
         d = bif.deq_rxq;
         @(posedge i_clk);
         #2;
         if (d && rx_q.size() > 0) void'(rx_q.pop_front());
         bif.rxq_empty = (rx_q.size() == 0);
         bif.rxq_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      end
   end

   initial begin
      bif.txq_full = 1'b0;
      forever begin
         @(posedge i_clk);
         #1;
         bif.txq_full = bp_en ? ~bif.txq_full : 1'b0;
      end
   end

   // Register bus responder: checks each request against the scoreboard, acks after ack_delay
   initial begin
      int rc;
      logic [41:0] obs, exp;
      bus_txn_t cur;
      rc = 0;
      cur = '0;
      bif.reg_ack   = 1'b0;
      bif.reg_rdata = 32'hBAD0BAD0;
      forever begin
         @(posedge i_clk);
         #1;
         bif.reg_ack   = 1'b0;
         bif.reg_rdata = 32'hBAD0BAD0;
         if (bif.reg_req) begin
            rc++;
            obs = {1'b0, bif.reg_we, bif.reg_addr, bif.reg_wdata};
            if (rc == 1) begin
               req_cnt++;
               req_start_cyc = cyc;
               exp = (bus_exp.size() > 0) ? {1'b0, bus_exp.pop_front()} : {42{1'b1}};
               chk("bus_txn", obs, exp);
               cur = obs[40:0];
            end else begin
               chk("bus_stable", obs, {1'b0, cur});
            end
            if (ack_delay >= 0 && rc - 1 == ack_delay) begin
               bif.reg_ack   = 1'b1;
               bif.reg_rdata = resp_data;
               ack_cyc       = cyc;
            end
         end else begin
            if (rc > 0) last_req_len = rc;
            rc = 0;
         end
      end
   end

   initial begin
      logic [8:0] e;
      forever begin
         @(negedge i_clk);
         if (bif.deq_rxq) last_deq_cyc = cyc;
         if (o_err) begin
            err_cnt++;
            err_cyc = cyc;
         end
         if (bif.enq_txq) begin
            tx_cnt++;
            if (first_enq_cyc < 0) first_enq_cyc = cyc;
            last_enq_cyc = cyc;
            chk("enq_while_full", bif.txq_full, 1'b0);
            e = (tx_exp.size() > 0) ? {1'b0, tx_exp.pop_front()} : 9'h1FF;
            chk("tx_byte", {1'b0, bif.txq_data}, e);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic wait_done(input string tag, input int max);
      int n;
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while ((o_busy || rx_q.size() != 0 || tx_exp.size() != 0) && n < max);
      chk({tag, "_done"}, {o_busy, rx_q.size() != 0, tx_exp.size() != 0}, 3'b000);
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      int e0, t0, r0;

      tick(3);
      @(negedge i_clk);
      chk("reset_outputs", out_vec(), '0);
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      tick(2);
      @(negedge i_clk);
      chk("idle_outputs", out_vec(), '0);
      @(posedge i_clk);
      #1;

      // write with ack three cycles into BUS
      first_enq_cyc = -1; e0 = err_cnt;
      ack_delay = 3;
      bus_exp.push_back(bus_txn_t'{1'b1, 8'h10, 32'hDEADBEEF});
      tx_exp.push_back(8'h4B);
      rx_q.push_back(8'h57); rx_q.push_back(8'h10); rx_q.push_back(8'hDE);
      rx_q.push_back(8'hAD); rx_q.push_back(8'hBE); rx_q.push_back(8'hEF);
      wait_done("write", 200);
      chk("write_req_latency", req_start_cyc, last_deq_cyc + 1);
      chk("write_k_latency", first_enq_cyc, ack_cyc + 1);
      chk("write_no_err", err_cnt - e0, 0);

      // read, ack in first BUS cycle
      first_enq_cyc = -1; t0 = tx_cnt;
      ack_delay = 0; resp_data = 32'h12345678;
      bus_exp.push_back(bus_txn_t'{1'b0, 8'h22, 32'h0});
      tx_exp.push_back(8'h12); tx_exp.push_back(8'h34);
      tx_exp.push_back(8'h56); tx_exp.push_back(8'h78);
      rx_q.push_back(8'h52); rx_q.push_back(8'h22);
      wait_done("read", 200);
      chk("read_tx_count", tx_cnt - t0, 4);
      chk("read_req_latency", req_start_cyc, last_deq_cyc + 1);
      chk("read_first_latency", first_enq_cyc, ack_cyc + 1);
      chk("read_back_to_back", last_enq_cyc - first_enq_cyc, 3);

      // unknown opcode, then a read that follows immediately
      first_enq_cyc = -1; e0 = err_cnt;
      resp_data = 32'hCAFEF00D;
      bus_exp.push_back(bus_txn_t'{1'b0, 8'h05, 32'h0});
      tx_exp.push_back(8'h45);
      tx_exp.push_back(8'hCA); tx_exp.push_back(8'hFE);
      tx_exp.push_back(8'hF0); tx_exp.push_back(8'h0D);
      rx_q.push_back(8'h41); rx_q.push_back(8'h52); rx_q.push_back(8'h05);
      wait_done("badop", 200);
      chk("badop_err_count", err_cnt - e0, 1);
      chk("badop_err_cycle", err_cyc, first_enq_cyc);

      // inter-byte timeout on a partial write
      e0 = err_cnt; t0 = tx_cnt; r0 = req_cnt;
      rx_q.push_back(8'h57); rx_q.push_back(8'h10); rx_q.push_back(8'hAA);
      wait_done("ib_timeout", 3 * T);
      chk("ib_timeout_err", err_cnt - e0, 1);
      chk("ib_timeout_no_tx", tx_cnt - t0, 0);
      chk("ib_timeout_no_req", req_cnt - r0, 0);
      chk("ib_timeout_cycle", err_cyc - last_deq_cyc, T + 1);

      t0 = tx_cnt;
      resp_data = 32'hA5A55A5A;
      bus_exp.push_back(bus_txn_t'{1'b0, 8'h00, 32'h0});
      tx_exp.push_back(8'hA5); tx_exp.push_back(8'hA5);
      tx_exp.push_back(8'h5A); tx_exp.push_back(8'h5A);
      rx_q.push_back(8'h52); rx_q.push_back(8'h00);
      wait_done("post_timeout_read", 200);
      chk("post_timeout_tx_count", tx_cnt - t0, 4);

      // TX backpressure toggling every cycle
      first_enq_cyc = -1; t0 = tx_cnt;
      bp_en = 1'b1;
      resp_data = 32'h01020304;
      bus_exp.push_back(bus_txn_t'{1'b0, 8'h33, 32'h0});
      tx_exp.push_back(8'h01); tx_exp.push_back(8'h02);
      tx_exp.push_back(8'h03); tx_exp.push_back(8'h04);
      rx_q.push_back(8'h52); rx_q.push_back(8'h33);
      wait_done("backpressure", 200);
      bp_en = 1'b0;
      chk("bp_tx_count", tx_cnt - t0, 4);
      chk("bp_spread", last_enq_cyc - first_enq_cyc, 6);
      tick(2);

      // bus timeout
      first_enq_cyc = -1; e0 = err_cnt;
      ack_delay = -1;
      bus_exp.push_back(bus_txn_t'{1'b0, 8'h44, 32'h0});
      tx_exp.push_back(8'h45);
      rx_q.push_back(8'h52); rx_q.push_back(8'h44);
      wait_done("bus_timeout", 3 * T);
      chk("bus_timeout_err", err_cnt - e0, 1);
      chk("bus_timeout_req_len", last_req_len, T + 1);
      chk("bus_timeout_err_cycle", err_cyc, first_enq_cyc);
      ack_delay = 0;

      // reset while collecting write data
      e0 = err_cnt; t0 = tx_cnt; r0 = req_cnt;
      rx_q.push_back(8'h57); rx_q.push_back(8'h10);
      rx_q.push_back(8'h11); rx_q.push_back(8'h22);
      tick(8);
      chk("mid_frame_busy", o_busy, 1'b1);
      i_rst = 1'b1;
      @(negedge i_clk);
      chk("reset_mid_outputs", out_vec(), '0);
      tick(1);
      i_rst = 1'b0;
      tick(20);
      chk("reset_no_tx", tx_cnt - t0, 0);
      chk("reset_no_req", req_cnt - r0, 0);
      chk("reset_no_err", err_cnt - e0, 0);
      chk("reset_idle", o_busy, 1'b0);

      t0 = tx_cnt;
      resp_data = 32'h0BADCAFE;
      bus_exp.push_back(bus_txn_t'{1'b0, 8'h7F, 32'h0});
      tx_exp.push_back(8'h0B); tx_exp.push_back(8'hAD);
      tx_exp.push_back(8'hCA); tx_exp.push_back(8'hFE);
      rx_q.push_back(8'h52); rx_q.push_back(8'h7F);
      wait_done("post_reset_read", 200);
      chk("post_reset_tx_count", tx_cnt - t0, 4);
      chk("scoreboard_empty", tx_exp.size() + bus_exp.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
